// File: rtl/clm_decode_stream_pkg.sv
// Shared types for the CLM masked-codeword receive path.
// A codeword is 8 data bits followed by D mask bits, numbered 0 (MSB) to N-1.
package clm_decode_stream_pkg;

  localparam int D           = 4;
  localparam int N           = 8 + D;
  localparam int BLOCK_BEATS = 16;

  typedef logic [0:N-1] state_t;
  typedef logic [0:7]   byte_t;
  typedef logic [0:D-1] red_poly_t;

  // Matrices are stored row-major: m[row][col].
  typedef logic [0:7][0:N-1] g_matrix_t;
  typedef logic [0:D-1][0:N-1] dn_matrix_t;
  typedef logic [0:N-1][0:7] n8_matrix_t;
  typedef logic [0:N-1][0:D-1] nd_matrix_t;

  typedef struct packed {
    state_t    c;
    byte_t     x;
    red_poly_t r;
  } beat_t;

  function automatic logic gf2_dot(input state_t a, input state_t b);
    return ^(a & b);
  endfunction

endpackage

// File: rtl/clm_decode_stream_reencode.sv
// Combinational CLM re-encoder: c = x*G ^ r*M over GF(2), full N-bit result.
module clm_reencode
  import clm_decode_stream_pkg::*;
(
  input  byte_t      x,
  input  red_poly_t  r,
  input  g_matrix_t  g,
  input  dn_matrix_t m,
  output state_t     c
);

  for (genvar k = 0; k < N; k++) begin : g_col
    logic [0:7]   g_col_k;
    logic [0:D-1] m_col_k;

    for (genvar i = 0; i < 8; i++) begin : g_gt
      assign g_col_k[i] = g[i][k];
    end
    for (genvar j = 0; j < D; j++) begin : g_mt
      assign m_col_k[j] = m[j][k];
    end

    assign c[k] = (^(x & g_col_k)) ^ (^(r & m_col_k));
  end

endmodule

// File: rtl/clm_decode_stream.sv
// Receive-side CLM decoder: two-stage pipeline recovering (x, r) from masked
// codewords, with re-encode fault compare, beat index and per-block fault flag.
module clm_decode_stream
  import clm_decode_stream_pkg::*;
#(
  parameter int BLOCK = BLOCK_BEATS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in_cw,
  input  g_matrix_t  G,
  input  dn_matrix_t M,
  input  n8_matrix_t Dx,
  input  nd_matrix_t Dr,
  output logic       out_valid,
  input  logic       out_ready,
  output byte_t      out_byte,
  output red_poly_t  out_r,
  output logic       out_fault,
  output logic       out_last,
  output logic       out_block_fault
);

  localparam logic [3:0] LAST_IDX = 4'(BLOCK - 1);

  byte_t     dec_x;
  red_poly_t dec_r;
  state_t    col;

  logic  s1_v, s2_v;
  beat_t s1, s2;
  logic  s2_adv, s1_en, out_acc;
  logic  [3:0] idx;
  logic  sticky;
  state_t re_c;
  logic  beat_fault;

  // Decode uses the matrices present at the S1 capture edge.
  always_comb begin
    dec_x = '0;
    dec_r = '0;
    col   = '0;
    for (int i = 0; i < 8; i++) begin
      for (int n = 0; n < N; n++) col[n] = Dx[n][i];
      dec_x[i] = gf2_dot(in_cw, col);
    end
    for (int j = 0; j < D; j++) begin
      for (int n = 0; n < N; n++) col[n] = Dr[n][j];
      dec_r[j] = gf2_dot(in_cw, col);
    end
  end

  assign s2_adv   = !s2_v || out_ready;
  assign s1_en    = !s1_v || s2_adv;
  assign in_ready = rst_n && !flush && s1_en;
  assign out_acc  = s2_v && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1   <= '0;
      s2   <= '0;
    end else begin
      if (s2_adv) begin
        s2_v <= s1_v;
        s2   <= s1;
      end
      if (s1_en) begin
        s1_v <= in_valid;
        if (in_valid) s1 <= '{c: in_cw, x: dec_x, r: dec_r};
      end
    end
  end

  // Compare uses G/M as they are while the beat sits in S2.
  clm_reencode u_reencode (
    .x (s2.x),
    .r (s2.r),
    .g (G),
    .m (M),
    .c (re_c)
  );

  assign beat_fault = (re_c != s2.c);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      idx    <= '0;
      sticky <= 1'b0;
    end else if (out_acc) begin
      if (idx == LAST_IDX) begin
        idx    <= '0;
        sticky <= 1'b0;
      end else begin
        idx    <= idx + 4'd1;
        sticky <= sticky | beat_fault;
      end
    end
  end

  assign out_valid       = s2_v;
  assign out_byte        = s2.x;
  assign out_r           = s2.r;
  assign out_fault       = s2_v && beat_fault;
  assign out_last        = s2_v && (idx == LAST_IDX);
  assign out_block_fault = s2_v && (sticky || beat_fault);

endmodule

// File: tb/tb_clm_decode_stream.sv
// Bench for clm_decode_stream with identity-style matrices so that c = {x, r}.
module tb_clm_decode_stream;
  import clm_decode_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  state_t     in_cw;
  g_matrix_t  G;
  dn_matrix_t M;
  n8_matrix_t Dx;
  nd_matrix_t Dr;
  byte_t      out_byte;
  red_poly_t  out_r;
  logic       out_fault, out_last, out_block_fault;

  g_matrix_t  g_id;
  dn_matrix_t m_id;
  n8_matrix_t dx_id;
  nd_matrix_t dr_id;

  always #5 clk = ~clk;

  clm_decode_stream dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .G(G), .M(M), .Dx(Dx), .Dr(Dr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_r(out_r), .out_fault(out_fault),
    .out_last(out_last), .out_block_fault(out_block_fault)
  );

  typedef struct {
    logic [11:0] cw;
    bit          dr_zero;
    logic [7:0]  x;
    logic [3:0]  r;
    bit          fault;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [3:0] r;
    bit         fault;
    bit         last;
    bit         bfault;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   pidx;
  bit   psticky;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    pidx    = 0;
    psticky = 1'b0;
  endtask

  // With Dr zeroed the recovered mask is 0 and the re-encode differs from c.
  function automatic vec_t mkvec(input logic [11:0] cw, input bit drz);
    vec_t v;
    v.cw      = cw;
    v.dr_zero = drz;
    v.x       = cw[11:4];
    v.r       = drz ? 4'h0 : cw[3:0];
    v.fault   = drz && (cw[3:0] != 4'h0);
    return v;
  endfunction

  task automatic send(input vec_t v);
    bit   done = 1'b0;
    int   waited = 0;
    exp_t e;
    in_cw    = v.cw;
    Dr       = v.dr_zero ? '0 : dr_id;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 50) begin
          n_vec++;
          n_err++;
          $display("FAIL send_timeout: in_ready stayed low, expected acceptance of %0h", v.cw);
          break;
        end
      end
    end
    if (done) begin
      e.x      = v.x;
      e.r      = v.r;
      e.fault  = v.fault;
      e.last   = (pidx == BLOCK_BEATS - 1);
      e.bfault = psticky | v.fault;
      psticky  = e.last ? 1'b0 : e.bfault;
      pidx     = e.last ? 0 : pidx + 1;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    Dr       = dr_id;
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got byte %0h, expected no output", out_byte);
      end else if (out_ready) begin
        mon_e = sb.pop_front();
        chk("out_byte",        32'(out_byte),        32'(mon_e.x));
        chk("out_r",           32'(out_r),           32'(mon_e.r));
        chk("out_fault",       32'(out_fault),       32'(mon_e.fault));
        chk("out_last",        32'(out_last),        32'(mon_e.last));
        chk("out_block_fault", 32'(out_block_fault), 32'(mon_e.bfault));
      end else begin
        chk("stall_byte", 32'(out_byte), 32'(sb[0].x));
        chk("stall_r",    32'(out_r),    32'(sb[0].r));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    g_id = '0; m_id = '0; dx_id = '0; dr_id = '0;
    for (int i = 0; i < 8; i++) begin
      g_id[i][i]  = 1'b1;
      dx_id[i][i] = 1'b1;
    end
    for (int j = 0; j < D; j++) begin
      m_id[j][8+j]  = 1'b1;
      dr_id[8+j][j] = 1'b1;
    end
    G = g_id; M = m_id; Dx = dx_id; Dr = dr_id;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",   32'(out_valid),       32'd0);
    chk("rst_in_ready",    32'(in_ready),        32'd0);
    chk("rst_out_byte",    32'(out_byte),        32'd0);
    chk("rst_out_r",       32'(out_r),           32'd0);
    chk("rst_out_fault",   32'(out_fault),       32'd0);
    chk("rst_out_last",    32'(out_last),        32'd0);
    chk("rst_block_fault", 32'(out_block_fault), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single beat: empty S2 right after acceptance, valid one edge later.
    send(mkvec(12'hA53, 1'b0));
    @(negedge clk);
    chk("lat_s1_only", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    model_clear();
    @(posedge clk); #1 flush = 1'b0;

    // 16 back-to-back beats x=0..15 plus a 17th that must not be last.
    for (int i = 0; i < 17; i++)
      tbl.push_back(mkvec({i[7:0], 4'(i ^ 5)}, 1'b0));
    // Fault beat partway through the next block, then into the following block.
    for (int i = 0; i < 18; i++)
      tbl.push_back(i == 6 ? mkvec(12'h5A7, 1'b1) : mkvec({8'(8'hC0 + i), 4'(i)}, 1'b0));
    foreach (tbl[k]) send(tbl[k]);

    // Backpressure: 5 stalled cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(mkvec({8'(8'h30 + i), 4'(15 - i)}, 1'b0));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Flush with two beats in flight.
    out_ready = 1'b0;
    send(mkvec(12'h111, 1'b0));
    send(mkvec(12'h222, 1'b0));
    @(negedge clk);
    chk("flush_inflight", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 flush = 1'b1;
    model_clear();
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_out", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) send(mkvec({8'(8'h80 + i), 4'(i)}, 1'b0));

    // Reset mid-block, after a fault beat has set the sticky flag.
    send(mkvec(12'h3C9, 1'b1));
    for (int i = 0; i < 4; i++) send(mkvec({8'(8'h50 + i), 4'(i)}, 1'b0));
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(mkvec(12'h7E4, 1'b0));

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
